// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_e           : receive framing FSM states (3-bit encoding)
//   DEFAULT_CLKS_PER_BIT : 50 MHz system clock / 115200 baud
//   LINE_IDLE            : level of an idle serial line (and of a stop bit)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_if
// Groups the serial input and the parity-checker / host facing outputs of
// the UART receive framer.
//   RxIn       : raw serial line (asynchronous, idles high)
//   RxBit      : last sampled bit, feeds the parity checker RxD input
//   Compute    : one-cycle strobe, RxBit holds a data bit
//   Check      : one-cycle strobe, RxBit holds the parity bit
//   RxData     : last completed byte
//   RxValid    : one-cycle pulse, RxData just updated
//   RxFrameErr : one-cycle pulse with RxValid, stop bit sampled low
//   Busy       : framer is not idle
// master = the framer, slave = the line driver / consumers.
// ---------------------------------------------------------------------------
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);

    logic                 RxIn;
    logic                 RxBit;
    logic                 Compute;
    logic                 Check;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxValid;
    logic                 RxFrameErr;
    logic                 Busy;

    modport master (
        input  RxIn,
        output RxBit,
        output Compute,
        output Check,
        output RxData,
        output RxValid,
        output RxFrameErr,
        output Busy
    );

    modport slave (
        output RxIn,
        input  RxBit,
        input  Compute,
        input  Check,
        input  RxData,
        input  RxValid,
        input  RxFrameErr,
        input  Busy
    );

endinterface

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter (0..CLKS_PER_BIT-1) for the receive FSM.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   clear     : restart the count at 0 on the next cycle (state entry)
//   half_tick : counter == CLKS_PER_BIT/2 - 1 (start-bit centre)
//   bit_tick  : counter == CLKS_PER_BIT - 1   (bit centre once aligned)
// ---------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign half_tick = (cnt_q == HALF_LAST);
    assign bit_tick  = (cnt_q == BIT_LAST);

    // Wrapping at the bit tick keeps consecutive data bits aligned to their
    // centres without the FSM having to clear between bits.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// UART receive framing controller. Synchronises the serial line, finds the
// start bit, samples every bit at its centre, assembles the byte LSB-first,
// strobes each data/parity bit to the downstream parity checker, and
// presents the finished byte with a valid pulse and framing-error flag.
//   Clock : system clock, rising edge
//   Reset : asynchronous active-low reset
//   rx_if : uart_rx_frame_if master modport (RxIn in; RxBit, Compute,
//           Check, RxData, RxValid, RxFrameErr, Busy out)
// ---------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    uart_rx_frame_if.master  rx_if
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 rx_s_q, rx_s_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_bit_q, rx_bit_d;
    logic                 compute_q, compute_d;
    logic                 check_q, check_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;

    logic                 half_tick;
    logic                 bit_tick;
    logic                 timer_clear;

    // Restarting the counter on every state change means the START half-bit
    // wait lands on the start-bit centre, and every later full-bit tick lands
    // on a bit centre.
    assign timer_clear = (state_d != state_q);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (Clock),
        .rst_n     (Reset),
        .clear     (timer_clear),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    // Strobes are registered alongside RxBit so that a strobe and the bit
    // it qualifies become visible in the same cycle.
    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_if.RxIn;
        rx_s_d      = sync1_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_bit_d    = rx_bit_q;
        compute_d   = 1'b0;
        check_d     = 1'b0;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s_q != LINE_IDLE) begin
                    state_d = START;
                end
            end

            START: begin
                if (half_tick) begin
                    if (rx_s_q == LINE_IDLE) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end

            DATA: begin
                if (bit_tick) begin
                    rx_bit_d           = rx_s_q;
                    shift_d[bit_idx_q] = rx_s_q;
                    compute_d          = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (bit_tick) begin
                    rx_bit_d = rx_s_q;
                    check_d  = 1'b1;
                    state_d  = STOP;
                end
            end

            // Returning to IDLE at the stop-bit centre leaves half a bit to
            // catch a back-to-back start edge.
            STOP: begin
                if (bit_tick) begin
                    rx_data_d   = shift_q;
                    valid_d     = 1'b1;
                    frame_err_d = (rx_s_q != LINE_IDLE);
                    state_d     = (rx_s_q == LINE_IDLE) ? IDLE : BREAK;
                end
            end

            // A held-low line must not be mistaken for a new start bit, so
            // only one framing error is reported per break.
            BREAK: begin
                if (rx_s_q == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            sync1_q     <= LINE_IDLE;
            rx_s_q      <= LINE_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_bit_q    <= 1'b1;
            compute_q   <= 1'b0;
            check_q     <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_bit_q    <= rx_bit_d;
            compute_q   <= compute_d;
            check_q     <= check_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_if.RxBit      = rx_bit_q;
    assign rx_if.Compute    = compute_q;
    assign rx_if.Check      = check_q;
    assign rx_if.RxData     = rx_data_q;
    assign rx_if.RxValid    = valid_q;
    assign rx_if.RxFrameErr = frame_err_q;
    assign rx_if.Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Scoreboard bench for uart_rx_frame at CLKS_PER_BIT=16, DATA_BITS=8.
// dut uses PARITY_EN=1, dut_np uses PARITY_EN=0. Stimulus pushes the
// expected strobe bits and frames into queues; a forked monitor pops and
// compares whenever a DUT strobe or valid pulse appears.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } frame_t;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    uart_rx_frame_if #(.DATA_BITS(8)) par_if ();
    uart_rx_frame_if #(.DATA_BITS(8)) np_if ();

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_EN    (1)
    ) dut (
        .Clock (clock),
        .Reset (reset_n),
        .rx_if (par_if)
    );

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_EN    (0)
    ) dut_np (
        .Clock (clock),
        .Reset (reset_n),
        .rx_if (np_if)
    );

    frame_t     exp_frames[$];
    logic       exp_bits[$];
    logic       exp_par[$];
    logic [7:0] exp_np[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int compute_cnt = 0;
    int last_compute_cyc = -1000;
    int np_compute_cnt = 0;
    int np_check_cnt = 0;
    int np_start_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Pops expectations whenever a DUT presents a strobe or a frame.
    task automatic monitor();
        frame_t f;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (par_if.Compute) begin
                    compute_cnt++;
                    checkOutput("strobe_overlap", par_if.Check, 1'b0);
                    if (cyc - last_compute_cyc <= 32)
                        checkOutput("compute_spacing", cyc - last_compute_cyc, CPB);
                    last_compute_cyc = cyc;
                    if (exp_bits.size() == 0)
                        checkOutput("unexpected_compute", par_if.Compute, 1'b0);
                    else
                        checkOutput("compute_rxbit", par_if.RxBit, exp_bits.pop_front());
                end
                if (par_if.Check) begin
                    if (exp_par.size() == 0)
                        checkOutput("unexpected_check", par_if.Check, 1'b0);
                    else
                        checkOutput("check_rxbit", par_if.RxBit, exp_par.pop_front());
                end
                if (par_if.RxFrameErr && !par_if.RxValid)
                    checkOutput("err_without_valid", par_if.RxFrameErr, 1'b0);
                if (par_if.RxValid) begin
                    if (exp_frames.size() == 0) begin
                        checkOutput("unexpected_valid", par_if.RxValid, 1'b0);
                    end else begin
                        f = exp_frames.pop_front();
                        checkOutput("rxdata", par_if.RxData, f.data);
                        checkOutput("frame_err", par_if.RxFrameErr, f.err);
                    end
                end
                if (np_if.Compute) np_compute_cnt++;
                if (np_if.Check) np_check_cnt++;
                if (np_if.RxValid) begin
                    if (exp_np.size() == 0) begin
                        checkOutput("np_unexpected_valid", np_if.RxValid, 1'b0);
                    end else begin
                        checkOutput("np_rxdata", np_if.RxData, exp_np.pop_front());
                        checkOutput("np_valid_latency", cyc - np_start_cyc, 155);
                    end
                end
            end
        end
    endtask

    // Sends one frame on par_if starting at a negedge. abort_bit >= 0 asserts
    // reset four cycles into that data bit and returns.
    task automatic applyStimulus(input logic [7:0] data, input logic par_bit,
                                 input logic stop_bit, input int abort_bit);
        frame_t f;
        for (int i = 0; i < 8; i++)
            if (abort_bit < 0 || i < abort_bit) exp_bits.push_back(data[i]);
        if (abort_bit < 0) begin
            exp_par.push_back(par_bit);
            f.data = data;
            f.err  = ~stop_bit;
            exp_frames.push_back(f);
        end
        par_if.RxIn = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            par_if.RxIn = data[i];
            if (i == abort_bit) begin
                repeat (4) @(negedge clock);
                reset_n     = 1'b0;
                par_if.RxIn = 1'b1;
                return;
            end
            repeat (CPB) @(negedge clock);
        end
        par_if.RxIn = par_bit;
        repeat (CPB) @(negedge clock);
        par_if.RxIn = stop_bit;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rxbit"}, par_if.RxBit, 1'b1);
        checkOutput({tag, "_compute"}, par_if.Compute, 1'b0);
        checkOutput({tag, "_check"}, par_if.Check, 1'b0);
        checkOutput({tag, "_valid"}, par_if.RxValid, 1'b0);
        checkOutput({tag, "_ferr"}, par_if.RxFrameErr, 1'b0);
        checkOutput({tag, "_busy"}, par_if.Busy, 1'b0);
        checkOutput({tag, "_rxdata"}, par_if.RxData, 8'h00);
    endtask

    initial begin
        int c0;
        logic [7:0] np_byte;
        reset_n     = 1'b0;
        par_if.RxIn = 1'b1;
        np_if.RxIn  = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        checkResetOutputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        $display("[TB] frame 0xA5");
        c0 = compute_cnt;
        applyStimulus(8'hA5, 1'b0, 1'b1, -1);
        repeat (20) @(negedge clock);
        checkOutput("a5_compute_count", compute_cnt - c0, 8);
        checkOutput("a5_busy_after", par_if.Busy, 1'b0);

        $display("[TB] false start");
        c0 = compute_cnt;
        par_if.RxIn = 1'b0;
        repeat (5) @(negedge clock);
        par_if.RxIn = 1'b1;
        checkOutput("glitch_busy_high", par_if.Busy, 1'b1);
        repeat (10) @(negedge clock);
        checkOutput("glitch_busy_low", par_if.Busy, 1'b0);
        checkOutput("glitch_compute_count", compute_cnt - c0, 0);

        $display("[TB] frame 0x3C with break");
        repeat (5) @(negedge clock);
        applyStimulus(8'h3C, 1'b0, 1'b0, -1);
        repeat (100) @(negedge clock);
        checkOutput("break_busy", par_if.Busy, 1'b1);
        checkOutput("break_frames_left", exp_frames.size(), 0);
        par_if.RxIn = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("break_busy_low", par_if.Busy, 1'b0);

        $display("[TB] back-to-back 0x01 0xFF");
        repeat (10) @(negedge clock);
        c0 = compute_cnt;
        applyStimulus(8'h01, 1'b1, 1'b1, -1);
        applyStimulus(8'hFF, 1'b0, 1'b1, -1);
        repeat (20) @(negedge clock);
        checkOutput("b2b_compute_count", compute_cnt - c0, 16);
        checkOutput("b2b_frames_left", exp_frames.size(), 0);

        $display("[TB] reset during data bit 4");
        applyStimulus(8'h5A, 1'b0, 1'b1, 4);
        #1;
        checkResetOutputs("abort");
        checkOutput("abort_bits_left", exp_bits.size(), 0);
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        applyStimulus(8'h5A, 1'b0, 1'b1, -1);
        repeat (20) @(negedge clock);

        $display("[TB] no-parity frame 0x81");
        np_byte = 8'h81;
        np_compute_cnt = 0;
        np_check_cnt   = 0;
        exp_np.push_back(np_byte);
        np_start_cyc = cyc;
        np_if.RxIn = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            np_if.RxIn = np_byte[i];
            repeat (CPB) @(negedge clock);
        end
        np_if.RxIn = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("np_check_count", np_check_cnt, 0);
        checkOutput("np_compute_count", np_compute_cnt, 8);
        checkOutput("np_frames_left", exp_np.size(), 0);

        checkOutput("bits_left", exp_bits.size(), 0);
        checkOutput("parity_left", exp_par.size(), 0);
        checkOutput("frames_left", exp_frames.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receive framing controller that sits directly upstream of the receive parity checker in the memory-mapped UART. It synchronises the serial input, locates the start bit, samples each bit mid-period and assembles the data byte LSB-first. It issues the one-cycle Compute and Check strobes, together with the sampled bit, that drive the parity checker, then flags framing errors and presents the completed byte with a valid pulse.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit and Check never asserts.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-low reset (0 = reset).
RxIn  in  1  raw serial line, asynchronous to Clock, idles high.
RxBit  out  1  last sampled bit; connects to the parity checker RxD input.
Compute  out  1  one-cycle strobe: RxBit holds a data bit.
Check  out  1  one-cycle strobe: RxBit holds the parity bit.
RxData  out  DATA_BITS  received byte; holds its value until the next frame completes.
RxValid  out  1  one-cycle pulse: RxData has been updated.
RxFrameErr  out  1  one-cycle pulse, same cycle as RxValid: the stop bit sampled 0.
Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, bit counter=0, cycle counter=0, both sync flops=1, RxBit=1, RxData=0, and Compute/Check/RxValid/RxFrameErr/Busy=0. Reset that asserts mid-frame aborts the frame with no RxValid pulse.
- Input sync: two flops; rx_s is the second flop output. All decisions use rx_s, which lags RxIn by 2 cycles.
- Cycle counter: counts 0..CLKS_PER_BIT-1; clears on every state entry. "Bit tick" means the counter equals CLKS_PER_BIT-1.
- IDLE: on rx_s=0, go to START with counter=0.
- START: when the counter reaches (CLKS_PER_BIT/2)-1 (integer division), sample rx_s.
  - If rx_s=1: false start; return to IDLE with no outputs.
  - If rx_s=0: go to DATA with bit index=0 and counter=0. All later samples therefore fall on bit centres.
- DATA: on each bit tick:
  - RxBit<=rx_s; shift register bit[index]<=rx_s; Compute=1 for that single cycle.
  - After index DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: on the bit tick, RxBit<=rx_s and Check=1 for one cycle, then go to STOP. Any parity mismatch is detected in the downstream parity checker.
- STOP: on the bit tick:
  - RxData<=shift register and RxValid=1 for one cycle.
  - RxFrameErr=1 in the same cycle iff rx_s=0.
  - If rx_s=1, go to IDLE. If rx_s=0, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. No strobes are issued, so a held-low line produces exactly one frame error.
- Strobe timing: Compute and Check are asserted in the same cycle that RxBit takes its new value, so the downstream block samples the bit together with its strobe. The strobes are never asserted together, and never outside DATA or PARITY respectively.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre, so a start edge half a bit later is detected normally.
- Busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - State enum IDLE/START/DATA/PARITY/STOP/BREAK, 3 bits.
  - Default CLKS_PER_BIT constant.
  - Line idle level constant (1).
- One natural sub-module: uart_bit_timer, which holds the cycle counter and produces the half-bit and bit tick outputs, with a clear input driven on every state entry.
- The FSM, shift register and strobe logic stay in uart_rx_frame.

Test Plan:
(All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, PARITY_EN=1.)
- Frame 0xA5, even-parity bit 0, stop bit 1: Compute pulses 8 times, 16 cycles apart, with RxBit sequence 1,0,1,0,0,1,0,1. Check pulses once with RxBit=0. RxValid pulses once with RxData=0xA5 and RxFrameErr=0.
- RxIn low for 5 cycles, then high: no Compute, Check or RxValid; Busy returns to 0 within 10 cycles of the low pulse.
- Frame 0x3C with stop bit 0, line held low for 100 more cycles: RxValid and RxFrameErr pulse together once with RxData=0x3C. No further strobes until the line goes high, then Busy=0.
- Frames 0x01 and 0xFF back-to-back with no idle gap: two RxValid pulses, RxData 0x01 then 0xFF, no errors, exactly 16 Compute pulses in total.
- Reset driven to 0 during data bit 4 of a frame: all outputs go to reset values immediately, with no RxValid. The next full frame 0x5A after Reset=1 is received correctly.
- PARITY_EN=0, frame 0x81: Check never asserts; RxValid pulses 9 bit periods after the start-bit centre with RxData=0x81.
